// File: rtl/noc_vc_fifo_pkg.sv
// Shared types and helpers for the multi-VC NoC input buffer (noc_vc_fifo).
package noc_vc_fifo_pkg;

  localparam int MAX_VC_W = 16;

  typedef logic [MAX_VC_W-1:0] vc_idx_t;

  typedef struct packed {
    logic empty;
    logic almost_full;
    logic full;
  } s_lane_flags;

  function automatic s_lane_flags get_lane_flags(input int count, input int depth,
                                                 input int threshold);
    s_lane_flags f;
    f.empty       = (count == 0);
    f.almost_full = (count >= threshold);
    f.full        = (count == depth);
    return f;
  endfunction

endpackage

// File: rtl/noc_vc_fifo_lane.sv
// One virtual-channel lane: fall-through FIFO with flags, credit pulse and,
// with `NOC_VC_FIFO_ERR_EN, sticky overflow/underflow flags.
module noc_vc_fifo_lane
  import noc_vc_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int THRESHOLD = DEPTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_full,
`ifdef NOC_VC_FIFO_ERR_EN
  output logic             o_err_overflow,
  output logic             o_err_underflow,
`endif
  output logic             o_credit
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             credit_reg;
  logic             push_ok, pop_ok;
  s_lane_flags      flags;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign flags   = get_lane_flags(32'(count_reg), DEPTH, THRESHOLD);
  assign push_ok = i_push && !flags.full && !i_clear;
  assign pop_ok  = i_pop && !flags.empty && !i_clear;

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (i_clear) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push_ok && !pop_ok)      count_next = count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      credit_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      credit_reg <= pop_ok;
    end
  end

  // Storage is read asynchronously so the head flit falls through with zero latency.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= i_data;
  end

  assign o_data        = flags.empty ? '0 : mem[rd_ptr_reg];
  assign o_empty       = flags.empty;
  assign o_almost_full = flags.almost_full;
  assign o_full        = flags.full;
  assign o_credit      = credit_reg;

`ifdef NOC_VC_FIFO_ERR_EN
  logic err_ovf_reg, err_unf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      err_ovf_reg <= 1'b0;
      err_unf_reg <= 1'b0;
    end else begin
      err_ovf_reg <= err_ovf_reg | (i_push && flags.full);
      err_unf_reg <= err_unf_reg | (i_pop && flags.empty);
    end
  end

  assign o_err_overflow  = err_ovf_reg;
  assign o_err_underflow = err_unf_reg;
`endif

endmodule

// File: rtl/noc_vc_fifo.sv
// Multi-VC NoC input buffer: one shared write link steered to NUM_VC lanes.
// Optional sticky error outputs when `NOC_VC_FIFO_ERR_EN is defined.
module noc_vc_fifo
  import noc_vc_fifo_pkg::*;
#(
  parameter  int NUM_VC    = 4,
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 4,
  parameter  int THRESHOLD = DEPTH - 1,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_VC-1:0]       i_clear,
  input  logic                    i_push,
  input  logic [VC_W-1:0]         i_push_vc,
  input  logic [WIDTH-1:0]        i_data,
  input  logic [NUM_VC-1:0]       i_pop,
  output logic [NUM_VC*WIDTH-1:0] o_data,
  output logic [NUM_VC-1:0]       o_empty,
  output logic [NUM_VC-1:0]       o_almost_full,
  output logic [NUM_VC-1:0]       o_full,
`ifdef NOC_VC_FIFO_ERR_EN
  output logic [NUM_VC-1:0]       o_err_overflow,
  output logic [NUM_VC-1:0]       o_err_underflow,
`endif
  output logic [NUM_VC-1:0]       o_credit
);

  logic [NUM_VC-1:0] push_sel;

  // An out-of-range VC index matches no lane, so the flit is dropped.
  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_lane
      assign push_sel[gi] = i_push && (vc_idx_t'(i_push_vc) == vc_idx_t'(gi));

      noc_vc_fifo_lane #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .THRESHOLD (THRESHOLD)
      ) u_lane (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (i_clear[gi]),
        .i_push          (push_sel[gi]),
        .i_data          (i_data),
        .i_pop           (i_pop[gi]),
        .o_data          (o_data[gi*WIDTH +: WIDTH]),
        .o_empty         (o_empty[gi]),
        .o_almost_full   (o_almost_full[gi]),
        .o_full          (o_full[gi]),
`ifdef NOC_VC_FIFO_ERR_EN
        .o_err_overflow  (o_err_overflow[gi]),
        .o_err_underflow (o_err_underflow[gi]),
`endif
        .o_credit        (o_credit[gi])
      );
    end
  endgenerate

endmodule
